// File: rtl/riscv_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_aes_pkg
// Purpose  : Shared types and constants for the AES command controller:
//            the command opcode enum, the controller FSM state enum and the
//            default WAIT timeout length.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_aes_pkg;

  // Command opcodes carried on req_op_i.
  typedef enum logic [1:0] {
    OP_LOAD_DATA = 2'b00,
    OP_LOAD_KEY  = 2'b01,
    OP_START     = 2'b10,
    OP_READ      = 2'b11
  } op_e;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

endpackage : riscv_aes_pkg
`default_nettype wire

// File: rtl/riscv_aes_timeout.sv
`default_nettype none
// ============================================================================
// Module   : riscv_aes_timeout
// Purpose  : Cycle counter for the controller WAIT state. Counts while en_i
//            is high and restarts from zero whenever en_i drops.
//            Only instantiated when RISCV_AES_TIMEOUT_EN is defined.
// Ports    : clk, rst     - clock / asynchronous active-high reset
//            en_i         - count enable (controller is in WAIT)
//            expired_o    - high during the TIMEOUT_CYCLES-th enabled cycle
// Revision : 1.0 - initial release
// ============================================================================
module riscv_aes_timeout
  import riscv_aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The controller leaves WAIT on this cycle, so the counter never wraps.
  assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule : riscv_aes_timeout
`default_nettype wire

// File: rtl/riscv_aes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_aes_ctrl
// Purpose  : Command front-end for an AES core. Accepts LOAD_DATA, LOAD_KEY,
//            START and READ commands, writes words into the core register
//            file, tracks which data/key words have been loaded, launches the
//            core and returns result words on a response channel.
// Ports    : clk, rst                     - clock / async active-high reset
//            req_valid_i/req_ready_o      - command handshake
//            req_op_i/req_idx_i/req_wdata_i - command payload
//            rf_waddr_o/rf_wdata_o/rf_wen_o/rf_sel_o - register-file write
//            rf_start_o                   - core start pulse
//            rf_rdata_i                   - four result words, word0 in LSBs
//            aes_done_i                   - core completion pulse
//            rsp_valid_o/rsp_data_o       - response channel
//            busy_o/err_o                 - status
// Config   : RISCV_AES_TIMEOUT_EN - when defined, WAIT aborts with err_o after
//            TIMEOUT_CYCLES cycles without aes_done_i.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_aes_ctrl
  import riscv_aes_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_op_i,
  input  logic [ADDR_WIDTH-1:0]   req_idx_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic [ADDR_WIDTH-1:0]   rf_waddr_o,
  output logic [DATA_WIDTH-1:0]   rf_wdata_o,
  output logic                    rf_wen_o,
  output logic                    rf_sel_o,
  output logic                    rf_start_o,
  input  logic [4*DATA_WIDTH-1:0] rf_rdata_i,
  input  logic                    aes_done_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    busy_o,
  output logic                    err_o
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   resp_idx_q, resp_idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    sel_q, sel_d;
  logic [3:0]              data_mask_q, data_mask_d;
  logic [3:0]              key_mask_q, key_mask_d;
  logic                    err_q, err_d;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   rd_words [4];
  logic [DATA_WIDTH-1:0]   rd_word;

  for (genvar g = 0; g < 4; g++) begin : g_words
    assign rd_words[g] = rf_rdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rd_word = rd_words[resp_idx_q[1:0]];

`ifdef RISCV_AES_TIMEOUT_EN
  riscv_aes_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == ST_WAIT),
    .expired_o (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    resp_idx_d  = resp_idx_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    sel_d       = sel_q;
    data_mask_d = data_mask_q;
    key_mask_d  = key_mask_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          case (op_e'(req_op_i))
            OP_LOAD_DATA, OP_LOAD_KEY: begin
              idx_d   = req_idx_i;
              wdata_d = req_wdata_i;
              sel_d   = req_op_i[0];
              state_d = ST_WRITE;
            end
            OP_START: begin
              // Launch only once every data and key word has been written.
              if ((&data_mask_q) && (&key_mask_q)) begin
                state_d = ST_START;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin // OP_READ
              resp_idx_d = req_idx_i;
              state_d    = ST_RESP;
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (sel_q) begin
          key_mask_d[idx_q[1:0]] = 1'b1;
        end else begin
          data_mask_d[idx_q[1:0]] = 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_START: begin
        data_mask_d = '0;
        key_mask_d  = '0;
        resp_idx_d  = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes priority over a simultaneous timeout.
        if (aes_done_i) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        rsp_data_d = rd_word;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      resp_idx_q  <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      sel_q       <= 1'b0;
      data_mask_q <= '0;
      key_mask_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      resp_idx_q  <= resp_idx_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      sel_q       <= sel_d;
      data_mask_q <= data_mask_d;
      key_mask_q  <= key_mask_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rf_wen_o    = (state_q == ST_WRITE);
  assign rf_start_o  = (state_q == ST_START);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rf_waddr_o  = idx_q;
  assign rf_wdata_o  = wdata_q;
  assign rf_sel_o    = sel_q;
  assign err_o       = err_q;
  // Live word while responding, last delivered word otherwise.
  assign rsp_data_o  = rsp_valid_o ? rd_word : rsp_data_q;

endmodule : riscv_aes_ctrl
`default_nettype wire

// File: tb/tb_riscv_aes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_aes_ctrl
// Purpose  : Directed self-checking bench for riscv_aes_ctrl.
//            Timeout scenarios are exercised when RISCV_AES_TIMEOUT_EN is
//            defined (DUT built with TIMEOUT_CYCLES = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_aes_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [1:0]   req_op_i = 2'b00;
  logic [1:0]   req_idx_i = 2'b00;
  logic [31:0]  req_wdata_i = 32'h0;
  logic [1:0]   rf_waddr_o;
  logic [31:0]  rf_wdata_o;
  logic         rf_wen_o;
  logic         rf_sel_o;
  logic         rf_start_o;
  logic [127:0] rf_rdata_i = 128'h0;
  logic         aes_done_i = 1'b0;
  logic         rsp_valid_o;
  logic [31:0]  rsp_data_o;
  logic         busy_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int start_cnt = 0;
  int rsp_cnt = 0;
  int base;

  riscv_aes_ctrl #(
    .ADDR_WIDTH     (2),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_idx_i   (req_idx_i),
    .req_wdata_i (req_wdata_i),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rf_wen_o    (rf_wen_o),
    .rf_sel_o    (rf_sel_o),
    .rf_start_o  (rf_start_o),
    .rf_rdata_i  (rf_rdata_i),
    .aes_done_i  (aes_done_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_wen_o)    wen_cnt++;
    if (rf_start_o)  start_cnt++;
    if (rsp_valid_o) rsp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One LOAD command: checks the single WRITE cycle and the return to IDLE.
  task automatic load(input logic [1:0] op, input logic [1:0] idx, input logic [31:0] wd);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_idx_i   = idx;
    req_wdata_i = wd;
    step();
    req_valid_i = 1'b0;
    check("wr_wen",   {31'b0, rf_wen_o}, 32'd1);
    check("wr_addr",  {30'b0, rf_waddr_o}, {30'b0, idx});
    check("wr_data",  rf_wdata_o, wd);
    check("wr_sel",   {31'b0, rf_sel_o}, {31'b0, op[0]});
    check("wr_ready", {31'b0, req_ready_o}, 32'd0);
    step();
    check("wr_end",   {31'b0, rf_wen_o}, 32'd0);
    check("wr_idle",  {31'b0, req_ready_o}, 32'd1);
  endtask

  task automatic load_all();
    load(2'b00, 2'd0, 32'h00112233);
    load(2'b00, 2'd1, 32'h44556677);
    load(2'b00, 2'd2, 32'h8899AABB);
    load(2'b00, 2'd3, 32'hCCDDEEFF);
    load(2'b01, 2'd0, 32'h00010203);
    load(2'b01, 2'd1, 32'h04050607);
    load(2'b01, 2'd2, 32'h08090A0B);
    load(2'b01, 2'd3, 32'h0C0D0E0F);
  endtask

  // Issues START and expects a launch: START cycle then WAIT.
  task automatic start_ok();
    req_valid_i = 1'b1;
    req_op_i    = 2'b10;
    step();
    req_valid_i = 1'b0;
    check("st_pulse", {31'b0, rf_start_o}, 32'd1);
    check("st_busy",  {31'b0, busy_o}, 32'd1);
    step();
    check("st_end",   {31'b0, rf_start_o}, 32'd0);
    check("wait_busy", {31'b0, busy_o}, 32'd1);
  endtask

  // Issues START and expects a rejection.
  task automatic start_reject(input string tag);
    base = start_cnt;
    req_valid_i = 1'b1;
    req_op_i    = 2'b10;
    step();
    req_valid_i = 1'b0;
    check({tag, "_err"},   {31'b0, err_o}, 32'd1);
    check({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    check({tag, "_busy"},  {31'b0, busy_o}, 32'd0);
    step();
    check({tag, "_errend"}, {31'b0, err_o}, 32'd0);
    check({tag, "_nostart"}, start_cnt, base);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_busy",  {31'b0, busy_o}, 32'd0);
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_wen",   {31'b0, rf_wen_o}, 32'd0);
    check("rst_start", {31'b0, rf_start_o}, 32'd0);
    check("rst_rsp",   {31'b0, rsp_valid_o}, 32'd0);
    check("rst_err",   {31'b0, err_o}, 32'd0);
    check("rst_rdata", rsp_data_o, 32'h0);
    check("rst_waddr", {30'b0, rf_waddr_o}, 32'h0);
    check("rst_wdata", rf_wdata_o, 32'h0);
    rst = 1'b0;
    step();

    // Full load, start, done after 10 cycles
    load_all();
    check("wen_count", wen_cnt, 32'd8);
    start_ok();
    rf_rdata_i = {32'h33333333, 32'h22222222, 32'h11111111, 32'h69C4E0D8};
    for (int i = 0; i < 8; i++) step();
    check("wait_hold", {31'b0, busy_o}, 32'd1);
    check("wait_norsp", {31'b0, rsp_valid_o}, 32'd0);
    aes_done_i = 1'b1;
    step();
    aes_done_i = 1'b0;
    check("done_rsp",   {31'b0, rsp_valid_o}, 32'd1);
    check("done_data",  rsp_data_o, 32'h69C4E0D8);
    step();
    check("done_end",   {31'b0, rsp_valid_o}, 32'd0);
    check("done_idle",  {31'b0, req_ready_o}, 32'd1);
    check("start_count", start_cnt, 32'd1);
    rf_rdata_i = {32'hA0A0A0A0, 32'hDEADBEEF, 32'hB0B0B0B0, 32'hC0C0C0C0};
    step();
    check("rsp_hold", rsp_data_o, 32'h69C4E0D8);

    // Done while idle is ignored
    aes_done_i = 1'b1;
    step();
    aes_done_i = 1'b0;
    check("stray_done_ready", {31'b0, req_ready_o}, 32'd1);
    check("stray_done_rsp",   {31'b0, rsp_valid_o}, 32'd0);

    // READ idx 2
    req_valid_i = 1'b1;
    req_op_i    = 2'b11;
    req_idx_i   = 2'd2;
    step();
    req_valid_i = 1'b0;
    check("read_valid", {31'b0, rsp_valid_o}, 32'd1);
    check("read_data",  rsp_data_o, 32'hDEADBEEF);
    check("read_busy",  {31'b0, busy_o}, 32'd1);
    step();
    check("read_end",   {31'b0, rsp_valid_o}, 32'd0);
    check("read_hold",  rsp_data_o, 32'hDEADBEEF);

    // Masks were cleared by the earlier START: immediate START rejected
    start_reject("rej_empty");

    // Key idx2 missing, data idx1 overwritten
    load(2'b00, 2'd0, 32'h00112233);
    load(2'b00, 2'd1, 32'h44556677);
    load(2'b00, 2'd1, 32'h12345678);
    load(2'b00, 2'd2, 32'h8899AABB);
    load(2'b00, 2'd3, 32'hCCDDEEFF);
    load(2'b01, 2'd0, 32'h00010203);
    load(2'b01, 2'd1, 32'h04050607);
    load(2'b01, 2'd3, 32'h0C0D0E0F);
    start_reject("rej_key2");
    load(2'b01, 2'd2, 32'h08090A0B);
    start_ok();
    check("start_count2", start_cnt, 32'd2);

    // Reset mid-WAIT, then a done: no response, masks cleared
    step();
    step();
    base = rsp_cnt;
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, busy_o}, 32'd0);
    step();
    rst = 1'b0;
    aes_done_i = 1'b1;
    step();
    aes_done_i = 1'b0;
    step();
    check("rst_abort_norsp", rsp_cnt, base);
    check("rst_abort_idle",  {31'b0, req_ready_o}, 32'd1);
    start_reject("rej_after_rst");

`ifdef RISCV_AES_TIMEOUT_EN
    // Timeout: no done during 16 WAIT cycles
    load_all();
    start_ok();                       // now in WAIT cycle 1
    base = rsp_cnt;
    for (int i = 0; i < 15; i++) begin
      check("to_noerr", {31'b0, err_o}, 32'd0);
      step();
    end
    check("to_cycle16_busy", {31'b0, busy_o}, 32'd1);
    step();
    check("to_err",    {31'b0, err_o}, 32'd1);
    check("to_idle",   {31'b0, req_ready_o}, 32'd1);
    check("to_norsp",  rsp_cnt, base);
    step();
    check("to_errend", {31'b0, err_o}, 32'd0);

    // Done exactly at WAIT cycle 16 beats the timeout
    load_all();
    start_ok();
    rf_rdata_i[31:0] = 32'h0BADF00D;
    for (int i = 0; i < 15; i++) step();
    aes_done_i = 1'b1;
    step();
    aes_done_i = 1'b0;
    check("race_rsp",  {31'b0, rsp_valid_o}, 32'd1);
    check("race_data", rsp_data_o, 32'h0BADF00D);
    check("race_noerr", {31'b0, err_o}, 32'd0);
    step();
    check("race_noerr2", {31'b0, err_o}, 32'd0);
    check("race_idle",  {31'b0, req_ready_o}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_riscv_aes_ctrl
`default_nettype wire
